// File: rtl/plane_fetch_seq_pkg.sv
// Shared constants for the fix/A/B plane fetch sequencer: VRAM map, pixel phases,
// FSM state encoding and tile-word fields. Row-scroll constants exist under PLANE_ROWSCROLL_EN.
package plane_fetch_seq_pkg;

  localparam int VA_W        = 13;
  localparam int GA_W        = 13;
  localparam int TILE_CODE_W = 8;
  localparam int TILE_COL_W  = 8;
  localparam int CODE10_W    = 10;

  localparam logic [VA_W-1:0] VRAM_BASE_FIX = 13'h0000;
  localparam logic [VA_W-1:0] VRAM_BASE_A   = 13'h0800;
  localparam logic [VA_W-1:0] VRAM_BASE_B   = 13'h1000;
`ifdef PLANE_ROWSCROLL_EN
  localparam logic [VA_W-1:0] VRAM_BASE_RS_A = 13'h1800;
  localparam logic [VA_W-1:0] VRAM_BASE_RS_B = 13'h1900;
  localparam logic [8:0]      PXH_RS_A       = 9'h190;
  localparam logic [8:0]      PXH_RS_B       = 9'h191;
`endif

  localparam logic [8:0] PXH_FIRST = 9'h020;
  localparam logic [8:0] PXH_LAST  = 9'h19F;

  // FSM state encoding, also visible on the debug port
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_RD_F  = 4'd1;
  localparam logic [3:0] ST_LT_F  = 4'd2;
  localparam logic [3:0] ST_RD_A  = 4'd3;
  localparam logic [3:0] ST_LT_A  = 4'd4;
  localparam logic [3:0] ST_RD_B  = 4'd5;
  localparam logic [3:0] ST_LT_B  = 4'd6;
  localparam logic [3:0] ST_RD_RS = 4'd7;
  localparam logic [3:0] ST_LT_RS = 4'd8;

  // Tile word is {col[7:0], code[7:0]}; the 10-bit code borrows col[1:0]
  function automatic logic [CODE10_W-1:0] tile_code10(input logic [15:0] word);
    return {word[TILE_CODE_W+1:TILE_CODE_W], word[TILE_CODE_W-1:0]};
  endfunction

  function automatic logic [TILE_COL_W-1:0] tile_col(input logic [15:0] word);
    return word[15:TILE_CODE_W];
  endfunction

endpackage

// File: rtl/plane_addr_calc.sv
// Combinational per-plane address math: scrolled X/Y, VRAM map address, tile row
// select (flip aware) and GFX ROM row address composition.
module plane_addr_calc
  import plane_fetch_seq_pkg::*;
(
  input  logic [8:0]          pxh,
  input  logic [7:0]          row,
  input  logic [8:0]          scrx,
  input  logic [7:0]          scry,
  input  logic                flip,
  input  logic [VA_W-1:0]     base,
  input  logic [CODE10_W-1:0] code10,
  input  logic [2:0]          ty3_lat,
  output logic [VA_W-1:0]     va,
  output logic [2:0]          ty3,
  output logic [GA_W-1:0]     ga
);

  logic       x_carry;
  logic [5:0] tile_x;
  logic [7:0] y;

  always_comb begin
    // x = pxh + scrx + 8 (mod 512); only x[8:3] is needed, so fold the fine carry in
    x_carry = ({1'b0, pxh[2:0]} + {1'b0, scrx[2:0]}) > 4'd7;
    tile_x  = pxh[8:3] + scrx[8:3] + 6'd1 + {5'd0, x_carry};
    y       = row + scry;
    ty3     = flip ? ~y[2:0] : y[2:0];
    va      = base + {2'b00, y[7:3], tile_x};
    ga      = {code10, ty3_lat};
  end

endmodule

// File: rtl/plane_fetch_seq.sv
// Tilemap fetch sequencer for fix/A/B planes: reads tile words from VRAM per 8-pixel group
// and presents GA/COL/fine-scroll to the plane processor. Row scroll under PLANE_ROWSCROLL_EN.
module plane_fetch_seq
  import plane_fetch_seq_pkg::*;
(
  input  logic        clk_24M,
  input  logic        nRES,
  input  logic        ce_6M,
  input  logic [8:0]  PXH,
  input  logic [7:0]  ROW,
  input  logic        FLIP_SCREEN,
  input  logic [8:0]  SCRX_A,
  input  logic [8:0]  SCRX_B,
  input  logic [7:0]  SCRY_A,
  input  logic [7:0]  SCRY_B,
  output logic [12:0] VA,
  input  logic [15:0] VD,
  output logic [12:0] GA,
  output logic [7:0]  COL,
  output logic        ZA1H,
  output logic        ZA2H,
  output logic        ZA4H,
  output logic        ZB1H,
  output logic        ZB2H,
  output logic        ZB4H,
  output logic [3:0]  dbg_state,
  output logic [1:0]  dbg_sub
);

  // VRAM bus: VA is registered in the RD_x cycle; VD is valid the following cycle
  // (LT_x) and is captured at the end of it. No handshake, fixed one-cycle latency.

  logic [3:0]      state_q;
  logic [1:0]      sub_q;
  logic            armed_q;
  logic [2:0]      ty3_q;
  logic [2:0]      za_q, zb_q;
  logic [GA_W-1:0] stg_f_ga, stg_a_ga, stg_b_ga;
  logic [7:0]      stg_f_col, stg_a_col, stg_b_col;

  logic            in_range;
  logic [8:0]      scrx_a_eff, scrx_b_eff;
  logic [8:0]      calc_scrx;
  logic [7:0]      calc_scry;
  logic [VA_W-1:0] calc_base, calc_va;
  logic [2:0]      calc_ty3;
  logic [GA_W-1:0] calc_ga;

  assign in_range = (PXH >= PXH_FIRST) && (PXH <= PXH_LAST);

`ifdef PLANE_ROWSCROLL_EN
  logic       rs_sel_q;
  logic [8:0] rs_pend_a, rs_pend_b, rs_act_a, rs_act_b;
  logic       rs_pend_a_vld, rs_pend_b_vld, rs_act_a_vld, rs_act_b_vld;

  assign scrx_a_eff = rs_act_a_vld ? rs_act_a : SCRX_A;
  assign scrx_b_eff = rs_act_b_vld ? rs_act_b : SCRX_B;

  // Offsets fetched during a line become active once that line's last pixel is reached
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      rs_sel_q      <= 1'b0;
      rs_pend_a     <= '0;
      rs_pend_b     <= '0;
      rs_act_a      <= '0;
      rs_act_b      <= '0;
      rs_pend_a_vld <= 1'b0;
      rs_pend_b_vld <= 1'b0;
      rs_act_a_vld  <= 1'b0;
      rs_act_b_vld  <= 1'b0;
    end else begin
      if (ce_6M && PXH == PXH_RS_A) rs_sel_q <= 1'b0;
      if (ce_6M && PXH == PXH_RS_B) rs_sel_q <= 1'b1;
      if (state_q == ST_LT_RS) begin
        if (!rs_sel_q) begin
          rs_pend_a     <= VD[8:0];
          rs_pend_a_vld <= 1'b1;
        end else begin
          rs_pend_b     <= VD[8:0];
          rs_pend_b_vld <= 1'b1;
        end
      end
      if (ce_6M && PXH == PXH_LAST) begin
        rs_act_a     <= rs_pend_a;
        rs_act_b     <= rs_pend_b;
        rs_act_a_vld <= rs_pend_a_vld;
        rs_act_b_vld <= rs_pend_b_vld;
      end
    end
  end
`else
  assign scrx_a_eff = SCRX_A;
  assign scrx_b_eff = SCRX_B;
`endif

  // Plane selection follows the pixel phase that launches each fetch
  always_comb begin
    calc_base = VRAM_BASE_FIX;
    calc_scrx = '0;
    calc_scry = '0;
    case (PXH[2:0])
      3'd2: begin
        calc_base = VRAM_BASE_A;
        calc_scrx = scrx_a_eff;
        calc_scry = SCRY_A;
      end
      3'd4: begin
        calc_base = VRAM_BASE_B;
        calc_scrx = scrx_b_eff;
        calc_scry = SCRY_B;
      end
      default: ;
    endcase
  end

  plane_addr_calc u_calc (
    .pxh     (PXH),
    .row     (ROW),
    .scrx    (calc_scrx),
    .scry    (calc_scry),
    .flip    (FLIP_SCREEN),
    .base    (calc_base),
    .code10  (tile_code10(VD)),
    .ty3_lat (ty3_q),
    .va      (calc_va),
    .ty3     (calc_ty3),
    .ga      (calc_ga)
  );

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      state_q   <= ST_IDLE;
      sub_q     <= 2'd0;
      armed_q   <= 1'b0;
      ty3_q     <= 3'd0;
      VA        <= '0;
      GA        <= '0;
      COL       <= '0;
      za_q      <= 3'd0;
      zb_q      <= 3'd0;
      stg_f_ga  <= '0;
      stg_a_ga  <= '0;
      stg_b_ga  <= '0;
      stg_f_col <= '0;
      stg_a_col <= '0;
      stg_b_col <= '0;
    end else begin
      sub_q <= ce_6M ? 2'd0 : sub_q + 2'd1;

      case (state_q)
        ST_RD_F: state_q <= ST_LT_F;
        ST_RD_A: state_q <= ST_LT_A;
        ST_RD_B: state_q <= ST_LT_B;
        ST_LT_F: begin
          stg_f_ga  <= calc_ga;
          stg_f_col <= tile_col(VD);
          state_q   <= ST_IDLE;
        end
        ST_LT_A: begin
          stg_a_ga  <= calc_ga;
          stg_a_col <= tile_col(VD);
          state_q   <= ST_IDLE;
        end
        ST_LT_B: begin
          stg_b_ga  <= calc_ga;
          stg_b_col <= tile_col(VD);
          state_q   <= ST_IDLE;
        end
`ifdef PLANE_ROWSCROLL_EN
        ST_RD_RS: state_q <= ST_LT_RS;
        ST_LT_RS: state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase

      if (ce_6M) begin
        if (!in_range) begin
          armed_q <= 1'b0;
        end else begin
          // armed_q gates windows until a full group has been fetched since reset/line start
          case (PXH[2:0])
            3'd0: begin
              if (armed_q) begin
                GA  <= stg_f_ga;
                COL <= stg_f_col;
              end
              za_q <= scrx_a_eff[2:0];
              zb_q <= scrx_b_eff[2:0];
            end
            3'd2: begin
              state_q <= ST_RD_A;
              VA      <= calc_va;
              ty3_q   <= calc_ty3;
            end
            3'd4: begin
              if (armed_q) begin
                GA  <= stg_a_ga;
                COL <= stg_a_col;
              end
              state_q <= ST_RD_B;
              VA      <= calc_va;
              ty3_q   <= calc_ty3;
            end
            3'd6: begin
              if (armed_q) begin
                GA  <= stg_b_ga;
                COL <= stg_b_col;
              end
              state_q <= ST_RD_F;
              VA      <= calc_va;
              ty3_q   <= calc_ty3;
              armed_q <= 1'b1;
            end
            default: ;
          endcase
`ifdef PLANE_ROWSCROLL_EN
          if (PXH == PXH_RS_A) begin
            state_q <= ST_RD_RS;
            VA      <= VRAM_BASE_RS_A + {5'd0, ROW};
          end
          if (PXH == PXH_RS_B) begin
            state_q <= ST_RD_RS;
            VA      <= VRAM_BASE_RS_B + {5'd0, ROW};
          end
`endif
        end
      end
    end
  end

  assign {ZA4H, ZA2H, ZA1H} = za_q;
  assign {ZB4H, ZB2H, ZB1H} = zb_q;
  assign dbg_state = state_q;
  assign dbg_sub   = sub_q;

endmodule
